// File: rtl/add_sat_pkg.sv
// Shared helpers for add_sat_pipe: signed clip function, range helpers and
// the stage payload type.
package add_sat_pkg;

  localparam int SAT_MAX_W = 32;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] data;
    logic                        hi;
    logic                        lo;
  } sat_payload_t;

  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

  // Sum arrives sign-extended to SAT_MAX_W; the caller keeps the low out_w bits.
  function automatic sat_payload_t sat_clip(input logic signed [SAT_MAX_W-1:0] sum,
                                            input int out_w);
    sat_payload_t res;
    res.data = sum;
    res.hi   = 1'b0;
    res.lo   = 1'b0;
    if (sum > sat_max(out_w)) begin
      res.data = sat_max(out_w);
      res.hi   = 1'b1;
    end else if (sum < sat_min(out_w)) begin
      res.data = sat_min(out_w);
      res.lo   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/add_sat_stage.sv
// One pipeline register with a valid bit; loads whenever it is empty or the
// downstream side takes its current contents.
module add_sat_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/add_sat_pipe.sv
// Two-stage signed add-then-saturate pipeline with valid/ready on both sides.
// Define ADD_SAT_STATS_EN to add the hi/lo clip counters and stats_clr.
module add_sat_pipe
  import add_sat_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
`ifdef ADD_SAT_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_a,
  input  logic signed [IN_W-1:0]  in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
`ifdef ADD_SAT_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [CNT_W-1:0]        sat_hi_cnt,
  output logic [CNT_W-1:0]        sat_lo_cnt
`endif
);

  localparam int SUM_W = IN_W + 1;
  localparam int PAY_W = OUT_W + 2;

  logic signed [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0]        w_s1Data;
  logic                    w_v1;
  logic                    w_s2Ready;
  sat_payload_t            w_clip;
  logic [PAY_W-1:0]        w_s2In;
  logic [PAY_W-1:0]        w_s2Out;
  logic                    w_unusedClipBits;

  // One extra bit makes the sum exact for any operand pair.
  assign w_sum = SUM_W'(in_a) + SUM_W'(in_b);

  add_sat_stage #(.W(SUM_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_sum),
    .o_valid (w_v1),
    .i_ready (w_s2Ready),
    .o_data  (w_s1Data)
  );

  assign w_clip           = sat_clip(SAT_MAX_W'(signed'(w_s1Data)), OUT_W);
  assign w_s2In           = {w_clip.data[OUT_W-1:0], w_clip.hi, w_clip.lo};
  assign w_unusedClipBits = ^w_clip.data[SAT_MAX_W-1:OUT_W];

  add_sat_stage #(.W(PAY_W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_v1),
    .o_ready (w_s2Ready),
    .i_data  (w_s2In),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2Out)
  );

  assign out_data = w_s2Out[PAY_W-1:2];
  assign out_sat  = |w_s2Out[1:0];

`ifdef ADD_SAT_STATS_EN
  logic             w_outFire;
  logic [CNT_W-1:0] r_hiCnt;
  logic [CNT_W-1:0] r_loCnt;

  assign w_outFire = out_valid && out_ready;

  // Counts clips actually delivered; sticks at all-ones, clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_hiCnt <= '0;
      r_loCnt <= '0;
    end else if (w_outFire) begin
      if (w_s2Out[1] && !(&r_hiCnt)) begin
        r_hiCnt <= r_hiCnt + CNT_W'(1);
      end
      if (w_s2Out[0] && !(&r_loCnt)) begin
        r_loCnt <= r_loCnt + CNT_W'(1);
      end
    end
  end

  assign sat_hi_cnt = r_hiCnt;
  assign sat_lo_cnt = r_loCnt;
`endif

endmodule

// File: tb/tb_add_sat_pipe.sv
// Scoreboard bench for add_sat_pipe: directed vectors push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_add_sat_pipe;

  localparam int IN_W  = 8;
  localparam int OUT_W = 4;
`ifdef ADD_SAT_STATS_EN
  localparam int CNT_W = 16;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_a;
  logic signed [IN_W-1:0]  in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
`ifdef ADD_SAT_STATS_EN
  logic                    stats_clr;
  logic [CNT_W-1:0]        sat_hi_cnt;
  logic [CNT_W-1:0]        sat_lo_cnt;
  int                      expHi = 0;
  int                      expLo = 0;
`endif

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
    logic                    hi;
    logic                    lo;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nMiss   = 0;
  int   waits;

  always #5 clk = ~clk;

  add_sat_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
`ifdef ADD_SAT_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef ADD_SAT_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .sat_hi_cnt (sat_hi_cnt),
    .sat_lo_cnt (sat_lo_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair and holds it until accepted; records the expected result.
  task automatic applyStimulus(input logic signed [IN_W-1:0] a, input logic signed [IN_W-1:0] b,
                               input logic signed [OUT_W-1:0] d, input logic s,
                               output int nWait);
    bit   ok;
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    nWait    = 0;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) break;
      nWait++;
    end
    if (ok) begin
      e = '{d, s, s && !d[OUT_W-1], s && d[OUT_W-1]};
      expQ.push_back(e);
    end else begin
      nChecks++;
      nMiss++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 100 cycles, want 1");
    end
  endtask

  task automatic waitDrain();
    in_valid = 1'b0;
    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("drain_queue", expQ.size(), 0);
  endtask

  task automatic checkCounters(input string name);
`ifdef ADD_SAT_STATS_EN
    checkOutput({name, "_hi_cnt"}, sat_hi_cnt, expHi);
    checkOutput({name, "_lo_cnt"}, sat_lo_cnt, expLo);
`endif
  endtask

  // Output-side monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nMiss++;
        $display("[TB] FAIL unexpected_output: got data %0d, want no output", out_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_sat", out_sat, e.sat);
`ifdef ADD_SAT_STATS_EN
        if (e.hi) expHi++;
        if (e.lo) expLo++;
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
`ifdef ADD_SAT_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_sat", out_sat, 0);
    checkCounters("reset");

    // Latency: empty after the accept edge, valid after the following one.
    step();
    applyStimulus(8'sd5, 8'sd1, 4'sd6, 1'b0, waits);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_cycle1_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("latency_cycle2_valid", out_valid, 1);
    waitDrain();

    step();
    applyStimulus(8'sd100, 8'sd27, 4'sd7, 1'b1, waits);
    waitDrain();
    checkCounters("hi_clip");

    step();
    applyStimulus(-8'sd128, -8'sd128, -4'sd8, 1'b1, waits);
    waitDrain();
    checkCounters("lo_clip");

    step();
    applyStimulus(-8'sd3, -8'sd5, -4'sd8, 1'b0, waits);
    waitDrain();
    checkCounters("min_boundary");

    // Back-to-back with out_ready high: every pair accepted without a wait.
    step();
    applyStimulus(8'sd3, 8'sd4, 4'sd7, 1'b0, waits);
    checkOutput("thru_wait0", waits, 0);
    applyStimulus(8'sd4, 8'sd4, 4'sd7, 1'b1, waits);
    checkOutput("thru_wait1", waits, 0);
    applyStimulus(-8'sd4, -8'sd5, -4'sd8, 1'b1, waits);
    checkOutput("thru_wait2", waits, 0);
    applyStimulus(-8'sd9, 8'sd9, 4'sd0, 1'b0, waits);
    checkOutput("thru_wait3", waits, 0);
    waitDrain();
    checkCounters("thru");

    // Backpressure: two accepts fill the pipe, output held stable until release.
    step();
    out_ready = 1'b0;
    applyStimulus(8'sd1, 8'sd2, 4'sd3, 1'b0, waits);
    applyStimulus(-8'sd7, 8'sd20, 4'sd7, 1'b1, waits);
    in_a = -8'sd50;
    in_b = 8'sd10;
    @(negedge clk);
    checkOutput("bp_in_ready_a", in_ready, 0);
    checkOutput("bp_hold_valid_a", out_valid, 1);
    checkOutput("bp_hold_data_a", out_data, 3);
    step();
    @(negedge clk);
    checkOutput("bp_in_ready_b", in_ready, 0);
    checkOutput("bp_hold_data_b", out_data, 3);
    checkOutput("bp_hold_sat_b", out_sat, 0);
    step();
    out_ready = 1'b1;
    applyStimulus(-8'sd50, 8'sd10, -4'sd8, 1'b1, waits);
    checkOutput("bp_resume_wait", waits, 0);
    applyStimulus(8'sd2, -8'sd3, -4'sd1, 1'b0, waits);
    waitDrain();
    checkCounters("bp");

    // Reset with both stages full discards them.
    step();
    out_ready = 1'b0;
    applyStimulus(8'sd9, 8'sd9, 4'sd7, 1'b1, waits);
    applyStimulus(-8'sd9, -8'sd9, -4'sd8, 1'b1, waits);
    in_valid = 1'b0;
    rst      = 1'b1;
    expQ.delete();
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
`ifdef ADD_SAT_STATS_EN
    expHi = 0;
    expLo = 0;
`endif
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_data", out_data, 0);
    checkCounters("midrst");

    step();
    applyStimulus(8'sd7, -8'sd1, 4'sd6, 1'b0, waits);
    waitDrain();

`ifdef ADD_SAT_STATS_EN
    // Clear coinciding with a hi-clip handshake must leave both counters at 0.
    step();
    applyStimulus(-8'sd100, -8'sd100, -4'sd8, 1'b1, waits);
    waitDrain();
    checkCounters("pre_clr");
    step();
    applyStimulus(8'sd100, 8'sd100, 4'sd7, 1'b1, waits);
    in_valid = 1'b0;
    step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    expHi = 0;
    expLo = 0;
    @(negedge clk);
    checkCounters("clr_wins");
`endif

    waitDrain();
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiss);
    $finish;
  end

endmodule
